// File: rtl/fp_operand_feeder.sv
// Operand-pair FIFO and load sequencer in front of the serial-load fp_adder.
// Issues start/A/B to the adder, waits for finished (or times out) and holds one result.
module fp_operand_feeder #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_a,
   input  logic [31:0]            in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_result,
   output logic                   out_timeout,
   output logic                   add_start,
   output logic [31:0]            add_data,
   input  logic                   add_finished,
   input  logic [31:0]            add_result,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned TmoW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
   localparam logic [31:0]     QNaN    = 32'h7FC0_0000;

   typedef enum logic [2:0] {StIdle, StStart, StOpA, StOpB, StWait} state_e;

   state_e          state_q;
   logic [63:0]     mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [31:0]     opa_q, opb_q;
   logic [TmoW-1:0] tmo_cnt_q;
   logic            out_valid_q, out_timeout_q, add_start_q;
   logic [31:0]     out_result_q, add_data_q;
   logic            push, pop;

   assign in_ready = count_q < Full;
   assign push     = in_valid && in_ready;
   // Only launch when the result slot will be free by the time this op captures.
   assign pop      = (state_q == StIdle) && (count_q != '0) && (!out_valid_q || out_ready);

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= {in_a, in_b};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         opa_q         <= '0;
         opb_q         <= '0;
         tmo_cnt_q     <= '0;
         add_start_q   <= 1'b0;
         add_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_timeout_q <= 1'b0;
         out_result_q  <= '0;
      end else begin
         // A capture in WAIT below overrides this release.
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  state_q        <= StStart;
                  {opa_q, opb_q} <= mem_q[rd_ptr_q];
                  add_start_q    <= 1'b1;
                  add_data_q     <= '0;
               end
            end
            StStart: begin
               state_q     <= StOpA;
               add_start_q <= 1'b0;
               add_data_q  <= opa_q;
            end
            StOpA: begin
               state_q    <= StOpB;
               add_data_q <= opb_q;
            end
            StOpB: begin
               state_q   <= StWait;
               tmo_cnt_q <= '0;
            end
            StWait: begin
               if (add_finished) begin
                  out_result_q  <= add_result;
                  out_timeout_q <= 1'b0;
                  out_valid_q   <= 1'b1;
                  state_q       <= StIdle;
               end else if (tmo_cnt_q == TmoLast) begin
                  out_result_q  <= QNaN;
                  out_timeout_q <= 1'b1;
                  out_valid_q   <= 1'b1;
                  state_q       <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_timeout = out_timeout_q;
   assign add_start   = add_start_q;
   assign add_data    = add_data_q;
   assign busy        = state_q != StIdle;
   assign count       = count_q;

endmodule

// File: tb/tb_fp_operand_feeder.sv
// Directed bench for fp_operand_feeder with a behavioural serial-load adder model.
module tb_fp_operand_feeder;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0, add_finished = 1'b0;
   logic [31:0] in_a = '0, in_b = '0, add_result = '0;
   logic        in_ready, out_valid, out_timeout, add_start, busy;
   logic [31:0] out_result, add_data;
   logic [2:0]  count;

   fp_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_timeout(out_timeout), .add_start(add_start), .add_data(add_data),
      .add_finished(add_finished), .add_result(add_result), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;
   vec_t vecs [10];

   int n_cmp = 0, n_err = 0;
   logic [31:0] exp_r[$], obs_r[$], exp_sa[$], exp_sb[$], obs_sa[$], obs_sb[$];
   logic        exp_t[$], obs_t[$];
   int idx_r = 0, idx_s = 0;

   // Adder model controls (written by the main sequence only).
   int m_delay = 5;
   bit m_never = 1'b0, m_sticky = 1'b0;
   // Adder model state (written by the model only).
   int ph = 0, wc = 0, n_starts = 0, m_err = 0;
   logic [31:0] ma, mb;

   function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].a == a && vecs[i].b == b) return vecs[i].r;
      end
      return 32'hFFFF_FFFF;
   endfunction

   // Serial-load adder: start, A, B, then finished after m_delay WAIT cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            ph = 0;
            add_finished = 1'b0;
         end else begin
            case (ph)
               0: if (add_start) begin
                  if (add_data !== 32'h0) m_err++;
                  ph = 1;
               end
               1: begin
                  if (add_start !== 1'b0) m_err++;
                  ma = add_data;
                  ph = 2;
               end
               2: begin
                  mb = add_data;
                  obs_sa.push_back(ma);
                  obs_sb.push_back(mb);
                  n_starts++;
                  wc = 0;
                  ph = 3;
               end
               3: if (!busy) begin
                  ph = 0;
                  add_finished = 1'b0;
               end else begin
                  wc++;
                  if (!m_never && wc == m_delay) begin
                     add_finished = 1'b1;
                     add_result = lookup(ma, mb);
                     ph = 4;
                  end else begin
                     add_finished = 1'b0;
                  end
               end
               default: begin
                  if (!m_sticky) add_finished = 1'b0;
                  ph = 0;
               end
            endcase
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            obs_r.push_back(out_result);
            obs_t.push_back(out_timeout);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic t);
      exp_sa.push_back(a);
      exp_sb.push_back(b);
      exp_r.push_back(r);
      exp_t.push_back(t);
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      while (!in_ready && n < 500) begin
         cyc();
         n++;
      end
      if (n >= 500) chk("push_accept", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((obs_r.size() < exp_r.size() || obs_sa.size() < exp_sa.size()) && n < 3000) begin
         cyc();
         n++;
      end
      repeat (5) cyc();
      chk({tag, "_nresults"}, 32'(obs_r.size()), 32'(exp_r.size()));
      chk({tag, "_nstarts"}, 32'(obs_sa.size()), 32'(exp_sa.size()));
      while (idx_r < exp_r.size() && idx_r < obs_r.size()) begin
         chk($sformatf("%s_result%0d", tag, idx_r), obs_r[idx_r], exp_r[idx_r]);
         chk($sformatf("%s_timeout%0d", tag, idx_r), 32'(obs_t[idx_r]), 32'(exp_t[idx_r]));
         idx_r++;
      end
      while (idx_s < exp_sa.size() && idx_s < obs_sa.size()) begin
         chk($sformatf("%s_opa%0d", tag, idx_s), obs_sa[idx_s], exp_sa[idx_s]);
         chk($sformatf("%s_opb%0d", tag, idx_s), obs_sb[idx_s], exp_sb[idx_s]);
         idx_s++;
      end
   endtask

   task automatic wait_out_valid(output int c);
      c = 0;
      while (!out_valid && c < 300) begin
         cyc();
         c++;
      end
   endtask

   initial begin
      int c, s;
      vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
      vecs[2] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
      vecs[3] = '{32'h0080_0000, 32'h8080_0000, 32'h0000_0000};
      vecs[4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
      vecs[5] = '{32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
      vecs[6] = '{32'h4040_0000, 32'h3F80_0000, 32'h4080_0000};
      vecs[7] = '{32'h40A0_0000, 32'hC040_0000, 32'h4000_0000};
      vecs[8] = '{32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000};
      vecs[9] = '{32'h4120_0000, 32'h4120_0000, 32'h41A0_0000};

      // Reset values.
      repeat (3) cyc();
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_timeout", 32'(out_timeout), 32'd0);
      chk("rst_out_result", out_result, 32'h0);
      chk("rst_add_start", 32'(add_start), 32'd0);
      chk("rst_add_data", add_data, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Single op: latency, load sequence, held result.
      push_pair(vecs[0].a, vecs[0].b);
      expect_op(vecs[0].a, vecs[0].b, vecs[0].r, 1'b0);
      chk("t1_idle_start", 32'(add_start), 32'd0);
      chk("t1_idle_count", 32'(count), 32'd1);
      cyc();
      chk("t1_start_pulse", 32'(add_start), 32'd1);
      chk("t1_start_data", add_data, 32'h0);
      chk("t1_start_busy", 32'(busy), 32'd1);
      chk("t1_start_count", 32'(count), 32'd0);
      cyc();
      chk("t1_opa_start", 32'(add_start), 32'd0);
      chk("t1_opa_data", add_data, vecs[0].a);
      cyc();
      chk("t1_opb_data", add_data, vecs[0].b);
      wait_out_valid(c);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_result", out_result, vecs[0].r);
      chk("t1_out_timeout", 32'(out_timeout), 32'd0);
      repeat (3) cyc();
      chk("t1_hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      cyc();
      chk("t1_release", 32'(out_valid), 32'd0);
      wait_drain("t1");

      // Back-to-back pairs with consumer always ready.
      for (int i = 1; i <= 3; i++) begin
         push_pair(vecs[i].a, vecs[i].b);
         expect_op(vecs[i].a, vecs[i].b, vecs[i].r, 1'b0);
      end
      wait_drain("t2");

      // Consumer stalled: one result held, FIFO fills, no further start.
      out_ready = 1'b0;
      for (int i = 4; i <= 8; i++) begin
         push_pair(vecs[i].a, vecs[i].b);
         expect_op(vecs[i].a, vecs[i].b, vecs[i].r, 1'b0);
      end
      in_valid = 1'b1;
      in_a = vecs[9].a;
      in_b = vecs[9].b;
      expect_op(vecs[9].a, vecs[9].b, vecs[9].r, 1'b0);
      repeat (30) cyc();
      chk("t3_held_valid", 32'(out_valid), 32'd1);
      chk("t3_held_result", out_result, vecs[4].r);
      chk("t3_count_full", 32'(count), 32'd4);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      s = n_starts;
      repeat (10) cyc();
      chk("t3_stable_result", out_result, vecs[4].r);
      chk("t3_stable_timeout", 32'(out_timeout), 32'd0);
      chk("t3_no_start", 32'(n_starts), 32'(s));
      out_ready = 1'b1;
      c = 0;
      while (!in_ready && c < 500) begin
         cyc();
         c++;
      end
      cyc();
      in_valid = 1'b0;
      wait_drain("t3");

      // Adder never finishes: timeout result after 64 WAIT cycles, next op runs normally.
      m_never = 1'b1;
      push_pair(vecs[1].a, vecs[1].b);
      push_pair(vecs[4].a, vecs[4].b);
      expect_op(vecs[1].a, vecs[1].b, 32'h7FC0_0000, 1'b1);
      expect_op(vecs[4].a, vecs[4].b, vecs[4].r, 1'b0);
      c = 0;
      while (!add_start && c < 100) begin
         cyc();
         c++;
      end
      wait_out_valid(c);
      m_never = 1'b0;
      chk("t4_timeout_cycles", 32'(c), 32'd67);
      chk("t4_timeout_result", out_result, 32'h7FC0_0000);
      chk("t4_timeout_flag", 32'(out_timeout), 32'd1);
      wait_drain("t4");

      // Finished on the last WAIT cycle beats the timeout.
      m_delay = TIMEOUT;
      push_pair(vecs[8].a, vecs[8].b);
      expect_op(vecs[8].a, vecs[8].b, vecs[8].r, 1'b0);
      c = 0;
      while (!add_start && c < 100) begin
         cyc();
         c++;
      end
      wait_out_valid(c);
      chk("t4b_cycles", 32'(c), 32'd67);
      chk("t4b_result", out_result, vecs[8].r);
      chk("t4b_flag", 32'(out_timeout), 32'd0);
      wait_drain("t4b");
      m_delay = 5;

      // Stale finished held across the next START/OPA/OPB must not be captured.
      m_sticky = 1'b1;
      push_pair(vecs[5].a, vecs[5].b);
      push_pair(vecs[7].a, vecs[7].b);
      expect_op(vecs[5].a, vecs[5].b, vecs[5].r, 1'b0);
      expect_op(vecs[7].a, vecs[7].b, vecs[7].r, 1'b0);
      wait_drain("t5");
      m_sticky = 1'b0;

      // Reset during WAIT with two pairs queued.
      m_never = 1'b1;
      push_pair(vecs[1].a, vecs[1].b);
      push_pair(vecs[2].a, vecs[2].b);
      push_pair(vecs[3].a, vecs[3].b);
      exp_sa.push_back(vecs[1].a);
      exp_sb.push_back(vecs[1].b);
      c = 0;
      while (ph != 3 && c < 100) begin
         cyc();
         c++;
      end
      repeat (3) cyc();
      chk("t6_pre_count", 32'(count), 32'd2);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      m_never = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_add_start", 32'(add_start), 32'd0);
      push_pair(vecs[6].a, vecs[6].b);
      expect_op(vecs[6].a, vecs[6].b, vecs[6].r, 1'b0);
      wait_drain("t6");

      chk("adder_protocol", 32'(m_err), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
